// File: rtl/fetch_pc_gen_pkg.sv
// Shared fetch-path constants and types: address/batch widths, fetch stride, default FTQ sizing.
// BranchPredictor imports the same package so both blocks agree on stride and history width.
package fetch_pc_gen_pkg;
    localparam int ADDR_WIDTH    = 32;
    localparam int IF_BATCH_SIZE = 2;
    localparam int INST_ADD_STEP = 4;
    localparam int FETCH_STRIDE  = IF_BATCH_SIZE * INST_ADD_STEP;
    localparam int BATCH_BITS    = IF_BATCH_SIZE * 32;
    localparam int DEF_FTQ_DEPTH = 4;
    localparam int DEF_GHR_BITS  = 8;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [BATCH_BITS-1:0] batch_t;

    function automatic addr_t next_seq_pc(input addr_t pc);
        return pc + addr_t'(FETCH_STRIDE);
    endfunction
endpackage

// File: rtl/fetch_pc_gen_if.sv
// Fetch-side bundle: backend redirect, predictor query, I-mem request/response and decode handoff.
// master = fetch_pc_gen, slave = the surrounding predictor / I-mem / decode environment.
interface fetch_pc_gen_if
    import fetch_pc_gen_pkg::*;
#(
    parameter int GHR_BITS = DEF_GHR_BITS
) ();
    logic                redirect_valid;
    addr_t               redirect_pc;
    logic                bp_fetch_valid;
    addr_t               bp_fetch_pc;
    logic                bp_pred_taken;
    addr_t               bp_pred_target;
    logic [GHR_BITS-1:0] bp_pred_hist;
    logic                imem_req_valid;
    addr_t               imem_req_addr;
    logic                imem_req_ready;
    logic                imem_resp_valid;
    batch_t              imem_resp_data;
    logic                out_valid;
    addr_t               out_pc;
    batch_t              out_insts;
    logic                out_pred_taken;
    addr_t               out_pred_target;
    logic [GHR_BITS-1:0] out_pred_hist;
    logic                out_ready;

    modport master (
        input  redirect_valid, redirect_pc,
        output bp_fetch_valid, bp_fetch_pc,
        input  bp_pred_taken, bp_pred_target, bp_pred_hist,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output out_valid, out_pc, out_insts, out_pred_taken, out_pred_target, out_pred_hist,
        input  out_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  bp_fetch_valid, bp_fetch_pc,
        output bp_pred_taken, bp_pred_target, bp_pred_hist,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  out_valid, out_pc, out_insts, out_pred_taken, out_pred_target, out_pred_hist,
        output out_ready
    );
endinterface

// File: rtl/fetch_pc_gen_chk.sv
// Protocol and occupancy properties for fetch_pc_gen.
module fetch_pc_gen_chk #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input logic             clk,
    input logic             rst,
    input logic             resp_valid,
    input logic             redirect_valid,
    input logic             fire,
    input logic [PTR_W-1:0] drop,
    input logic [PTR_W-1:0] count,
    input logic [PTR_W-1:0] unfilled
);
    localparam int SUM_W = PTR_W + 1;

    a_resp_has_owner: assert property (@(posedge clk) disable iff (rst)
        resp_valid |-> (drop != {PTR_W{1'b0}} || unfilled != {PTR_W{1'b0}}));

    a_occupancy_bound: assert property (@(posedge clk) disable iff (rst)
        (SUM_W'(drop) + SUM_W'(count)) <= SUM_W'(DEPTH));

    a_no_fire_on_redirect: assert property (@(posedge clk) disable iff (rst)
        redirect_valid |-> !fire);
endmodule

// File: rtl/fetch_target_queue.sv
// Fetch target queue: in-order entries {pc, prediction, insts} with write/fill/read pointers.
// Entries between rd and fill hold data; entries between fill and wr await their I-mem response.
module fetch_target_queue
    import fetch_pc_gen_pkg::*;
#(
    parameter int DEPTH    = DEF_FTQ_DEPTH,
    parameter int GHR_BITS = DEF_GHR_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  addr_t                  push_pc,
    input  logic                   push_taken,
    input  addr_t                  push_target,
    input  logic [GHR_BITS-1:0]    push_hist,
    input  logic                   fill,
    input  batch_t                 fill_data,
    input  logic                   pop,
    output logic                   head_valid,
    output addr_t                  head_pc,
    output batch_t                 head_insts,
    output logic                   head_taken,
    output addr_t                  head_target,
    output logic [GHR_BITS-1:0]    head_hist,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] unfilled
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    addr_t               pc_mem_r     [DEPTH];
    logic                taken_mem_r  [DEPTH];
    addr_t               target_mem_r [DEPTH];
    logic [GHR_BITS-1:0] hist_mem_r   [DEPTH];
    batch_t              data_mem_r   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_r, fill_ptr_r, rd_ptr_r;
    logic [IDX_W-1:0] wr_idx_s, fill_idx_s, rd_idx_s;

    // Pointer arithmetic and head read; the extra pointer MSB separates full from empty.
    always_comb begin
        wr_idx_s    = wr_ptr_r[IDX_W-1:0];
        fill_idx_s  = fill_ptr_r[IDX_W-1:0];
        rd_idx_s    = rd_ptr_r[IDX_W-1:0];
        count       = wr_ptr_r - rd_ptr_r;
        unfilled    = wr_ptr_r - fill_ptr_r;
        head_valid  = (fill_ptr_r != rd_ptr_r);
        head_pc     = pc_mem_r[rd_idx_s];
        head_insts  = data_mem_r[rd_idx_s];
        head_taken  = taken_mem_r[rd_idx_s];
        head_target = target_mem_r[rd_idx_s];
        head_hist   = hist_mem_r[rd_idx_s];
    end

    // Entry storage; validity is tracked by the pointers, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem_r[wr_idx_s]     <= push_pc;
            taken_mem_r[wr_idx_s]  <= push_taken;
            target_mem_r[wr_idx_s] <= push_target;
            hist_mem_r[wr_idx_s]   <= push_hist;
        end
        if (fill && !flush) begin
            data_mem_r[fill_idx_s] <= fill_data;
        end
    end

    // Pointer state; flush discards every entry at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            fill_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            fill_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
        end else begin
            if (push) wr_ptr_r   <= wr_ptr_r + PTR_W'(1'b1);
            if (fill) fill_ptr_r <= fill_ptr_r + PTR_W'(1'b1);
            if (pop)  rd_ptr_r   <= rd_ptr_r + PTR_W'(1'b1);
        end
    end
endmodule

// File: rtl/fetch_pc_gen.sv
// Next-PC generator: drives predictor query and I-mem requests from pc_q, queues work in the FTQ,
// and drops responses that belong to requests issued before the latest redirect.
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter int    FTQ_DEPTH = DEF_FTQ_DEPTH,
    parameter addr_t RESET_PC  = 32'h0000_0000,
    parameter int    GHR_BITS  = DEF_GHR_BITS
) (
    input logic            clk,
    input logic            rst,
    fetch_pc_gen_if.master bus
);
    localparam int PTR_W = $clog2(FTQ_DEPTH) + 1;
    localparam int SUM_W = PTR_W + 1;

    addr_t               pc_r;
    logic [PTR_W-1:0]    drop_r;
    logic [PTR_W-1:0]    count_s, unfilled_s;
    logic [SUM_W-1:0]    occupancy_s;
    logic                issue_ok_s, fire_s, fill_s, pop_s;
    logic                head_valid_s, head_taken_s;
    addr_t               head_pc_s, head_target_s;
    batch_t              head_insts_s;
    logic [GHR_BITS-1:0] head_hist_s;

    // Issue gating counts responses still owed to flushed requests as occupied slots.
    always_comb begin
        occupancy_s = SUM_W'(count_s) + SUM_W'(drop_r);
        issue_ok_s  = !rst && !bus.redirect_valid && (occupancy_s < SUM_W'(FTQ_DEPTH));
        fire_s      = issue_ok_s && bus.imem_req_ready;
        fill_s      = bus.imem_resp_valid && !bus.redirect_valid && (drop_r == {PTR_W{1'b0}});
        pop_s       = head_valid_s && bus.out_ready && !bus.redirect_valid;
    end

    assign bus.bp_fetch_valid  = issue_ok_s;
    assign bus.bp_fetch_pc     = pc_r;
    assign bus.imem_req_valid  = issue_ok_s;
    assign bus.imem_req_addr   = pc_r;
    assign bus.out_valid       = head_valid_s;
    assign bus.out_pc          = head_pc_s;
    assign bus.out_insts       = head_insts_s;
    assign bus.out_pred_taken  = head_taken_s;
    assign bus.out_pred_target = head_target_s;
    assign bus.out_pred_hist   = head_hist_s;

    // Fetch PC: redirect wins, otherwise advance on fire along the predicted path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else if (bus.redirect_valid) begin
            pc_r <= bus.redirect_pc;
        end else if (fire_s) begin
            pc_r <= bus.bp_pred_taken ? bus.bp_pred_target : next_seq_pc(pc_r);
        end
    end

    // Stale-response counter: a redirect adds every unfilled request; a response in that cycle is one of them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_r <= {PTR_W{1'b0}};
        end else if (bus.redirect_valid) begin
            drop_r <= drop_r + unfilled_s - PTR_W'(bus.imem_resp_valid);
        end else if (bus.imem_resp_valid && (drop_r != {PTR_W{1'b0}})) begin
            drop_r <= drop_r - PTR_W'(1'b1);
        end
    end

    fetch_target_queue #(
        .DEPTH    (FTQ_DEPTH),
        .GHR_BITS (GHR_BITS)
    ) u_ftq (
        .clk         (clk),
        .rst         (rst),
        .flush       (bus.redirect_valid),
        .push        (fire_s),
        .push_pc     (pc_r),
        .push_taken  (bus.bp_pred_taken),
        .push_target (bus.bp_pred_target),
        .push_hist   (bus.bp_pred_hist),
        .fill        (fill_s),
        .fill_data   (bus.imem_resp_data),
        .pop         (pop_s),
        .head_valid  (head_valid_s),
        .head_pc     (head_pc_s),
        .head_insts  (head_insts_s),
        .head_taken  (head_taken_s),
        .head_target (head_target_s),
        .head_hist   (head_hist_s),
        .count       (count_s),
        .unfilled    (unfilled_s)
    );

    fetch_pc_gen_chk #(
        .DEPTH (FTQ_DEPTH)
    ) u_chk (
        .clk            (clk),
        .rst            (rst),
        .resp_valid     (bus.imem_resp_valid),
        .redirect_valid (bus.redirect_valid),
        .fire           (fire_s),
        .drop           (drop_r),
        .count          (count_s),
        .unfilled       (unfilled_s)
    );
endmodule
